ps2_device_tx: RTL and testbench



---
 rtl/ps2_pkg.sv | 28 ++
 rtl/ps2_clk_div.sv | 47 ++++
 rtl/ps2_device_tx.sv | 197 +++++++++++++++++++
 tb/tb_ps2_device_tx.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 device-side transmitter:
//   state_t     - transmitter FSM states (IDLE, FRAME, GAP)
//   FRAME_BITS  - bits per PS/2 frame (start, 8 data, parity, stop)
//   START_BIT   - level of the start bit
//   STOP_BIT    - level of the stop bit
//   odd_parity  - parity bit that makes the 9-bit {parity, data} word odd
// ---------------------------------------------------------------------------
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FRAME = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam int   FRAME_BITS = 11;
    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;

    // Returns 1 when the data byte holds an even number of ones, so the
    // transmitted nine bits always carry an odd count.
    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_clk_div.sv
// ---------------------------------------------------------------------------
// ps2_clk_div
// Half-period timer for the PS/2 bit cell.
// Parameters:
//   CLK_HALF  - system clocks per SCL half-period (2..65535)
// Ports:
//   clk       in  system clock
//   rst       in  synchronous active-high reset
//   en        in  count while high (frame in progress)
//   clr       in  synchronous clear of counter and phase
//   half_tick out high on the last cycle of each half-period
//   phase     out 0 = SCL high half of the cell, 1 = SCL low half
// ---------------------------------------------------------------------------
module ps2_clk_div
    import ps2_pkg::*;
#(
    parameter int CLK_HALF = 2000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic half_tick,
    output logic phase
);

    logic [15:0] cnt;

    assign half_tick = en && (cnt == 16'(CLK_HALF - 1));

    // Counter restarts from zero every half-period; phase flips with it so
    // the parent knows whether the tick ends the high or the low half.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (en) begin
            if (half_tick) begin
                cnt   <= '0;
                phase <= ~phase;
            end else begin
                cnt <= cnt + 16'd1;
            end
        end
    end

endmodule

// File: rtl/ps2_device_tx.sv
// ---------------------------------------------------------------------------
// ps2_device_tx
// PS/2 device-side (keyboard-emulator) transmitter. Sends one byte per
// valid/ready handshake as an 11-bit frame: start 0, 8 data bits LSB first,
// odd parity, stop 1. Drives its own SCL and SDA, then holds both lines
// idle for IDLE_GAP cycles before accepting the next byte.
//
// Optional feature macro: PS2_INHIBIT_EN
//   When defined, scl_in is synchronized and a low line while SCL is driven
//   high is treated as a host inhibit: it blocks tx_ready in IDLE and aborts
//   a frame (tx_abort pulse) before bit 10's SCL fall. When undefined,
//   scl_in is ignored and tx_abort is always 0.
//
// Parameters:
//   CLK_HALF  - system clocks per SCL half-period (2..65535)
//   IDLE_GAP  - idle cycles after each frame (1..65535)
// Ports:
//   clk       in  system clock
//   rst       in  synchronous active-high reset
//   tx_data   in  byte to send, sampled on handshake
//   tx_valid  in  parent has a byte
//   tx_ready  out block can accept a byte
//   busy      out frame or idle gap in progress
//   tx_done   out one-cycle pulse on the first idle-gap cycle
//   tx_abort  out one-cycle pulse when a frame is abandoned
//   scl_in    in  line-level SCL readback
//   SCL       out PS/2 clock, idle 1
//   SDA       out PS/2 data, idle 1
// ---------------------------------------------------------------------------
module ps2_device_tx
    import ps2_pkg::*;
#(
    parameter int CLK_HALF = 2000,
    parameter int IDLE_GAP = 4000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_abort,
    input  logic       scl_in,
    output logic       SCL,
    output logic       SDA
);

    localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

    state_t      state;
    logic [7:0]  shift_reg;
    logic        parity;
    logic [3:0]  bit_idx;
    logic [15:0] gap_cnt;
    logic        scl_q;
    logic        sda_q;
    logic        done_q;
    logic        abort_q;
    logic        rst_done;
    logic        half_tick;
    logic        phase;
    logic        inhibit;
    logic        abort_req;

    ps2_clk_div #(
        .CLK_HALF (CLK_HALF)
    ) u_clk_div (
        .clk       (clk),
        .rst       (rst),
        .en        (state == FRAME),
        .clr       (state != FRAME),
        .half_tick (half_tick),
        .phase     (phase)
    );

`ifdef PS2_INHIBIT_EN
    logic scl_meta;
    logic scl_sync;
    logic scl_d1;
    logic scl_d2;

    // The driven SCL is delayed by the same two cycles as the synchronizer,
    // so our own falling edges read back through scl_in never look like an
    // inhibit.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_meta <= 1'b1;
            scl_sync <= 1'b1;
            scl_d1   <= 1'b1;
            scl_d2   <= 1'b1;
        end else begin
            scl_meta <= scl_in;
            scl_sync <= scl_meta;
            scl_d1   <= scl_q;
            scl_d2   <= scl_d1;
        end
    end

    assign inhibit = scl_d2 && !scl_sync;

    // Aborting is allowed up to, but not including, the cycle that makes
    // bit 10's SCL fall; after that the frame is allowed to finish.
    assign abort_req = (state == FRAME) && inhibit &&
                       ((bit_idx != LAST_BIT) || (!phase && !half_tick));
`else
    logic unused_scl_in;
    assign unused_scl_in = scl_in;
    assign inhibit       = 1'b0;
    assign abort_req     = 1'b0;
`endif

    assign tx_ready = (state == IDLE) && rst_done && !rst && !inhibit;
    assign busy     = (state != IDLE);
    assign tx_done  = done_q;
    assign tx_abort = abort_q;
    assign SCL      = scl_q;
    assign SDA      = sda_q;

    // Transmit FSM. SDA changes only at cell starts (the end of a low half),
    // giving the receiver a full half-period of setup before each SCL fall.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shift_reg <= '0;
            parity    <= 1'b0;
            bit_idx   <= '0;
            gap_cnt   <= '0;
            scl_q     <= 1'b1;
            sda_q     <= 1'b1;
            done_q    <= 1'b0;
            abort_q   <= 1'b0;
            rst_done  <= 1'b0;
        end else begin
            rst_done <= 1'b1;
            done_q   <= 1'b0;
            abort_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (tx_valid && tx_ready) begin
                        shift_reg <= tx_data;
                        parity    <= odd_parity(tx_data);
                        bit_idx   <= '0;
                        scl_q     <= 1'b1;
                        sda_q     <= START_BIT;
                        state     <= FRAME;
                    end
                end
                FRAME: begin
                    if (abort_req) begin
                        scl_q     <= 1'b1;
                        sda_q     <= 1'b1;
                        abort_q   <= 1'b1;
                        shift_reg <= '0;
                        gap_cnt   <= '0;
                        state     <= GAP;
                    end else if (half_tick) begin
                        if (!phase) begin
                            scl_q <= 1'b0;
                        end else begin
                            scl_q <= 1'b1;
                            if (bit_idx == LAST_BIT) begin
                                sda_q   <= 1'b1;
                                done_q  <= 1'b1;
                                gap_cnt <= '0;
                                state   <= GAP;
                            end else begin
                                bit_idx <= bit_idx + 4'd1;
                                // Cells 1..8 take data LSB first, then parity, then stop.
                                if (bit_idx <= 4'd7) begin
                                    sda_q     <= shift_reg[0];
                                    shift_reg <= {1'b0, shift_reg[7:1]};
                                end else if (bit_idx == 4'd8) begin
                                    sda_q <= parity;
                                end else begin
                                    sda_q <= STOP_BIT;
                                end
                            end
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == 16'(IDLE_GAP - 1)) begin
                        gap_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 16'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_device_tx.sv
// ---------------------------------------------------------------------------
// tb_ps2_device_tx
// Self-checking bench for ps2_device_tx with CLK_HALF=4, IDLE_GAP=8.
// A PS/2 receiver model samples SDA on every SCL fall and checks each
// decoded frame against a scoreboard queue filled when bytes are sent.
// Build with +define+PS2_INHIBIT_EN to also exercise host inhibit.
// ---------------------------------------------------------------------------
module tb_ps2_device_tx;

    localparam int CLK_HALF     = 4;
    localparam int IDLE_GAP     = 8;
    localparam int FRAME_CYCLES = 22 * CLK_HALF;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       tx_done;
    logic       tx_abort;
    logic       scl_in;
    logic       SCL;
    logic       SDA;
    logic       scl_force;

    typedef struct {
        logic [7:0] data;
        logic       parity;
    } vec_t;

    vec_t       vectors [8];
    logic [8:0] sb_queue [$];
    int         tests_run    = 0;
    int         tests_failed = 0;
    int         frames_sent  = 0;
    int         frames_rx    = 0;

    ps2_device_tx #(
        .CLK_HALF (CLK_HALF),
        .IDLE_GAP (IDLE_GAP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .busy     (busy),
        .tx_done  (tx_done),
        .tx_abort (tx_abort),
        .scl_in   (scl_in),
        .SCL      (SCL),
        .SDA      (SDA)
    );

    always #5 clk = ~clk;

    // Line readback follows the driven clock unless a host pulls it low.
    assign scl_in = scl_force ? 1'b0 : SCL;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string name, input int limit);
        int cycles;
        cycles = 0;
        while (tx_ready !== 1'b1 && cycles < limit) begin
            step();
            cycles++;
        end
        check_output(name, tx_ready, 1);
    endtask

    task automatic wait_done(input string name, input int limit, output int cycles);
        cycles = 0;
        while (tx_done !== 1'b1 && cycles < limit) begin
            step();
            cycles++;
        end
        check_output(name, tx_done, 1);
    endtask

    // Receiver model: collects 11 bits on SCL falls and checks the frame.
    logic        prev_scl = 1'b1;
    int          rx_count = 0;
    logic [10:0] rx_bits;
    logic [8:0]  exp_item;

    always @(negedge clk) begin
        if (rst === 1'b1 || tx_abort === 1'b1) begin
            rx_count = 0;
            prev_scl = 1'b1;
        end else begin
            if (prev_scl === 1'b1 && SCL === 1'b0) begin
                rx_bits[rx_count] = SDA;
                rx_count++;
                if (rx_count == 11) begin
                    rx_count = 0;
                    frames_rx++;
                    check_output("rx_start_bit", rx_bits[0], 0);
                    check_output("rx_stop_bit", rx_bits[10], 1);
                    check_output("rx_expected_frame", sb_queue.size() != 0, 1);
                    if (sb_queue.size() != 0) begin
                        exp_item = sb_queue.pop_front();
                        check_output("rx_data", rx_bits[8:1], exp_item[7:0]);
                        check_output("rx_parity", rx_bits[9], exp_item[8]);
                    end
                end
            end
            prev_scl = SCL;
        end
    end

    // Sends one byte, checks frame timing, pokes tx_valid mid-frame (and
    // optionally in the gap) and measures the idle gap.
    task automatic apply_stimulus(input vec_t v, input bit poke_gap);
        int   n;
        int   g;
        logic lines_bad;
        wait_ready("ready_before_send", 200);
        tx_data  = v.data;
        tx_valid = 1'b1;
        sb_queue.push_back({v.parity, v.data});
        frames_sent++;
        step();
        tx_valid = 1'b0;
        tx_data  = ~v.data;
        check_output("start_sda", SDA, 0);
        check_output("busy_at_start", busy, 1);
        check_output("ready_in_frame", tx_ready, 0);
        n = 1;
        while (tx_done !== 1'b1 && n < FRAME_CYCLES + 20) begin
            step();
            n++;
            if (n == CLK_HALF)     check_output("scl_before_fall", SCL, 1);
            if (n == CLK_HALF + 1) check_output("first_scl_fall", SCL, 0);
            if (n == 20) tx_valid = 1'b1;
            if (n == 21) tx_valid = 1'b0;
        end
        check_output("done_latency", n, FRAME_CYCLES + 1);
        check_output("done_lines", {SCL, SDA, busy}, 3'b111);
        g = 0;
        lines_bad = 1'b0;
        while (tx_ready !== 1'b1 && g < IDLE_GAP + 20) begin
            if (SCL !== 1'b1 || SDA !== 1'b1) lines_bad = 1'b1;
            if (poke_gap && g == 2) begin
                tx_valid = 1'b1;
                tx_data  = 8'h55;
            end
            if (poke_gap && g == 3) tx_valid = 1'b0;
            step();
            g++;
            if (g == 1) check_output("done_pulse_width", tx_done, 0);
        end
        check_output("gap_length", g, IDLE_GAP);
        check_output("gap_lines_idle", lines_bad, 0);
        check_output("busy_after_gap", busy, 0);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int   n;
        int   k;
        logic done_seen;

        vectors[0] = '{8'h1C, 1'b0};
        vectors[1] = '{8'h00, 1'b1};
        vectors[2] = '{8'hFF, 1'b1};
        vectors[3] = '{8'h55, 1'b1};
        vectors[4] = '{8'hF0, 1'b1};
        vectors[5] = '{8'h5A, 1'b1};
        vectors[6] = '{8'h80, 1'b0};
        vectors[7] = '{8'hA3, 1'b1};

        rst       = 1'b1;
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        scl_force = 1'b0;
        repeat (3) step();
        check_output("reset_scl", SCL, 1);
        check_output("reset_sda", SDA, 1);
        check_output("reset_ready", tx_ready, 0);
        check_output("reset_busy", busy, 0);
        check_output("reset_done", tx_done, 0);
        check_output("reset_abort", tx_abort, 0);
        rst = 1'b0;
        check_output("ready_as_rst_drops", tx_ready, 0);
        step();
        check_output("ready_after_reset", tx_ready, 1);

        for (int i = 0; i < 8; i++) begin
            apply_stimulus(vectors[i], i == 3);
        end

        // Back-to-back: tx_valid held high across two bytes.
        wait_ready("b2b_ready", 200);
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        sb_queue.push_back({1'b1, 8'h00});
        frames_sent++;
        step();
        tx_data = 8'hFF;
        sb_queue.push_back({1'b1, 8'hFF});
        frames_sent++;
        wait_done("b2b_first_done", FRAME_CYCLES + 20, n);
        check_output("b2b_first_latency", n + 1, FRAME_CYCLES + 1);
        k = 0;
        while (SDA !== 1'b0 && k < IDLE_GAP + 20) begin
            step();
            k++;
        end
        check_output("b2b_restart_gap", k, IDLE_GAP + 1);
        tx_valid = 1'b0;
        wait_done("b2b_second_done", FRAME_CYCLES + 20, n);
        wait_ready("b2b_ready_after", IDLE_GAP + 20);

        // Reset during bit 4 of 0x07 truncates the frame.
        tx_data  = 8'h07;
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        n = 1;
        while (n < 34) begin
            step();
            n++;
        end
        check_output("bit4_scl_high", SCL, 1);
        check_output("bit4_sda", SDA, 0);
        rst = 1'b1;
        step();
        check_output("midrst_lines", {SCL, SDA}, 2'b11);
        check_output("midrst_busy", busy, 0);
        check_output("midrst_ready", tx_ready, 0);
        rst = 1'b0;
        check_output("midrst_ready_drop_cycle", tx_ready, 0);
        step();
        check_output("midrst_ready_after", tx_ready, 1);
        done_seen = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (tx_done === 1'b1) done_seen = 1'b1;
            step();
        end
        check_output("midrst_no_done", done_seen, 0);

`ifdef PS2_INHIBIT_EN
        // Host pulls SCL low during bit 3's high phase.
        wait_ready("inh_ready", 200);
        tx_data  = 8'h1C;
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        n = 1;
        while (n < 25) begin
            step();
            n++;
        end
        scl_force = 1'b1;
        k = 0;
        while (tx_abort !== 1'b1 && k < 20) begin
            step();
            k++;
        end
        check_output("abort_seen", tx_abort, 1);
        check_output("abort_latency", k, 3);
        check_output("abort_lines", {SCL, SDA}, 2'b11);
        check_output("abort_busy", busy, 1);
        step();
        check_output("abort_pulse_width", tx_abort, 0);
        scl_force = 1'b0;
        wait_ready("abort_ready_return", IDLE_GAP + 20);
        scl_force = 1'b1;
        repeat (3) step();
        check_output("inhibit_blocks_ready", tx_ready, 0);
        scl_force = 1'b0;
        repeat (3) step();
        check_output("inhibit_release_ready", tx_ready, 1);
`endif

        repeat (20) step();
        check_output("scoreboard_drained", sb_queue.size(), 0);
        check_output("frames_received", frames_rx, frames_sent);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
